// File: rtl/irrigation_minute_timer.sv
// rtl/irrigation_minute_timer.sv - BCD minute countdown driving an irrigation valve
//
// Counts a loaded BCD duration (00-99 minutes) down once per rising edge of
// carry_in, holding the valve on while counting and pulsing done on expiry.
//
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-low reset
//   carry_in   minute carry level from the tens-of-seconds stage
//   start      load dur_tens/dur_units and begin (IDLE only)
//   abort      cancel irrigation (RUN only)
//   dur_tens   BCD tens digit of the duration
//   dur_units  BCD units digit of the duration
//   rem_tens   BCD tens digit of the remaining minutes
//   rem_units  BCD units digit of the remaining minutes
//   valve      valve drive, high in RUN
//   busy       high in RUN and FINISH
//   done       one-cycle pulse on normal expiry
//   err        sticky invalid-load flag
module irrigation_minute_timer #(
   parameter int MAX_TENS = 9
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       carry_in,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] dur_tens,
   input  logic [3:0] dur_units,
   output logic [3:0] rem_tens,
   output logic [3:0] rem_units,
   output logic       valve,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [3:0] MAX_TENS_L = MAX_TENS[3:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t state;
   logic   carry_q;
   logic   tick;
   logic   load_bad;
   logic   load_zero;
   logic   last_minute;

   // carry_q resets high so a carry level already present at reset release
   // is not mistaken for a fresh minute.
   assign tick        = carry_in & ~carry_q;
   assign load_bad    = (dur_tens > 4'd9) || (dur_units > 4'd9) || (dur_tens > MAX_TENS_L);
   assign load_zero   = (dur_tens == 4'd0) && (dur_units == 4'd0);
   // 01 (or a defensive 00) finishes on this tick instead of wrapping.
   assign last_minute = (rem_tens == 4'd0) && (rem_units <= 4'd1);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state     <= IDLE;
         carry_q   <= 1'b1;
         rem_tens  <= 4'd0;
         rem_units <= 4'd0;
         valve     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         carry_q <= carry_in;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               valve <= 1'b0;
               busy  <= 1'b0;
               if (start) begin
                  if (load_bad) begin
                     err <= 1'b1;
                  end else if (load_zero) begin
                     err       <= 1'b0;
                     rem_tens  <= 4'd0;
                     rem_units <= 4'd0;
                     state     <= FINISH;
                     busy      <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     err       <= 1'b0;
                     rem_tens  <= dur_tens;
                     rem_units <= dur_units;
                     state     <= RUN;
                     valve     <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  rem_tens  <= 4'd0;
                  rem_units <= 4'd0;
                  state     <= IDLE;
                  valve     <= 1'b0;
                  busy      <= 1'b0;
               end else if (tick) begin
                  if (last_minute) begin
                     rem_tens  <= 4'd0;
                     rem_units <= 4'd0;
                     state     <= FINISH;
                     valve     <= 1'b0;
                     done      <= 1'b1;
                  end else if (rem_units != 4'd0) begin
                     rem_units <= rem_units - 4'd1;
                  end else begin
                     rem_units <= 4'd9;
                     rem_tens  <= rem_tens - 4'd1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               valve <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               valve <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irrigation_minute_timer.sv
// tb/tb_irrigation_minute_timer.sv - scoreboard bench for irrigation_minute_timer
module tb_irrigation_minute_timer;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       carry_in = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] dur_tens = 4'd0;
   logic [3:0] dur_units = 4'd0;
   logic [3:0] rem_tens;
   logic [3:0] rem_units;
   logic       valve;
   logic       busy;
   logic       done;
   logic       err;

   irrigation_minute_timer dut (
      .clk       (clk),
      .clear     (clear),
      .carry_in  (carry_in),
      .start     (start),
      .abort     (abort),
      .dur_tens  (dur_tens),
      .dur_units (dur_units),
      .rem_tens  (rem_tens),
      .rem_units (rem_units),
      .valve     (valve),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;

   // Reference model: remaining minutes as a plain integer.
   int  model_rem = 0;
   bit  model_run = 1'b0;
   bit  model_err = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_rem(input int v);
      ev_t e;
      e.is_done = 1'b0;
      e.val     = v;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      ev_t e;
      e.is_done = 1'b1;
      e.val     = 0;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input bit is_done, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_output kind=%0d value=%0d expected=none at %0t", is_done, v, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", int'(is_done), int'(e.is_done));
         if (!is_done && !e.is_done) chk("rem_event", v, e.val);
      end
   endtask

   // Monitor: every change of the remaining count and every done cycle is
   // an output event matched in order against the scoreboard.
   initial begin
      int prev_rem;
      int cur;
      prev_rem = 0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         cur = int'(rem_tens) * 10 + int'(rem_units);
         if (cur != prev_rem) begin
            pop_cmp(1'b0, cur);
            prev_rem = cur;
         end
         if (done) pop_cmp(1'b1, 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valve"}, int'(valve), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), int'(model_err));
   endtask

   task automatic do_start(input int t, input int u);
      int d;
      d = t * 10 + u;
      dur_tens  = 4'(t);
      dur_units = 4'(u);
      start     = 1'b1;
      if (t > 9 || u > 9) begin
         model_err = 1'b1;
         cyc(1);
         start = 1'b0;
         chk("bad_load_err", int'(err), 1);
         chk("bad_load_valve", int'(valve), 0);
         chk("bad_load_rem", int'(rem_tens) * 10 + int'(rem_units), model_rem);
      end else if (d == 0) begin
         model_err = 1'b0;
         if (model_rem != 0) push_rem(0);
         push_done();
         model_rem = 0;
         cyc(1);
         start = 1'b0;
         chk("zero_load_done", int'(done), 1);
         chk("zero_load_busy", int'(busy), 1);
         chk("zero_load_valve", int'(valve), 0);
         chk("zero_load_err", int'(err), 0);
         cyc(1);
         chk_idle_outputs("zero_after");
      end else begin
         model_err = 1'b0;
         if (model_rem != d) push_rem(d);
         model_rem = d;
         model_run = 1'b1;
         cyc(1);
         start = 1'b0;
         chk("load_valve", int'(valve), 1);
         chk("load_busy", int'(busy), 1);
         chk("load_err", int'(err), 0);
      end
      dur_tens  = 4'($urandom_range(0, 15));
      dur_units = 4'($urandom_range(0, 15));
   endtask

   task automatic do_tick();
      bit finishing;
      finishing = 1'b0;
      if (model_run) begin
         model_rem = model_rem - 1;
         push_rem(model_rem);
         if (model_rem == 0) begin
            push_done();
            model_run = 1'b0;
            finishing = 1'b1;
         end
      end
      carry_in = 1'b1;
      cyc(1);
      if (finishing) begin
         chk("expiry_done", int'(done), 1);
         chk("expiry_valve", int'(valve), 0);
         chk("expiry_busy", int'(busy), 1);
      end else begin
         chk("tick_valve", int'(valve), int'(model_run));
      end
      chk("tick_rem", int'(rem_tens) * 10 + int'(rem_units), model_rem);
      cyc(1);
      if (finishing) chk_idle_outputs("post_expiry");
      cyc($urandom_range(0, 2));
      carry_in = 1'b0;
      cyc(1 + $urandom_range(0, 3));
   endtask

   task automatic do_abort(input bit with_tick);
      if (model_rem != 0) push_rem(0);
      model_rem = 0;
      model_run = 1'b0;
      carry_in  = with_tick;
      abort     = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk_idle_outputs("abort");
      chk("abort_rem", int'(rem_tens) * 10 + int'(rem_units), 0);
      carry_in = 1'b0;
      cyc(2);
   endtask

   task automatic stray_start_in_run();
      dur_tens  = 4'd0;
      dur_units = 4'd1;
      start     = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("stray_start_valve", int'(valve), 1);
      chk("stray_start_rem", int'(rem_tens) * 10 + int'(rem_units), model_rem);
   endtask

   initial begin
      int d;
      int abort_at;
      // 1: reset with carry high; the held level must not tick.
      #1 clear = 1'b0;
      #20;
      @(posedge clk);
      #1 clear = 1'b1;
      mon_en = 1'b1;
      cyc(10);
      chk_idle_outputs("reset");
      chk("reset_rem", int'(rem_tens) * 10 + int'(rem_units), 0);
      carry_in = 1'b0;
      cyc(2);

      // 2: 03 countdown
      do_start(0, 3);
      repeat (3) do_tick();

      // 3: 10 -> 09 borrow, then expiry
      do_start(1, 0);
      repeat (10) do_tick();

      // 4: 25, two ticks, abort colliding with a tick
      do_start(2, 5);
      repeat (2) do_tick();
      do_abort(1'b1);

      // 5: invalid units digit, then a valid 00 load
      do_start(0, 10);
      chk_idle_outputs("after_bad");
      do_start(0, 0);

      // 6: asynchronous reset mid-run
      do_start(0, 5);
      repeat (2) do_tick();
      if (model_rem != 0) push_rem(0);
      model_rem = 0;
      model_run = 1'b0;
      model_err = 1'b0;
      #2 clear = 1'b0;
      #1;
      chk("async_valve", int'(valve), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(done), 0);
      chk("async_rem", int'(rem_tens) * 10 + int'(rem_units), 0);
      cyc(2);
      clear = 1'b1;
      cyc(1);
      do_tick();
      chk_idle_outputs("after_async");

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) do_start($urandom_range(10, 15), $urandom_range(0, 15));
            else do_start($urandom_range(0, 9), $urandom_range(10, 15));
            do_tick();
         end else begin
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 12);
            do_start(d / 10, d % 10);
            if (d > 0) begin
               abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d - 1) : -1;
               for (int k = 0; k < d; k++) begin
                  if (k == abort_at) begin
                     do_abort(1'($urandom_range(0, 1)));
                     break;
                  end
                  if ($urandom_range(0, 7) == 0) stray_start_in_run();
                  do_tick();
               end
            end
            if ($urandom_range(0, 3) == 0) do_tick();
         end
      end

      cyc(4);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
